// File: rtl/flag_pkg.sv
// flag_pkg: NZCV bit positions, condition codes and scheduler states.
package flag_pkg;
  localparam int FLAG_N = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 0;
  typedef enum logic [3:0] {
    EQ, NE, HS, LO, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL, NV
  } cond_e;
  typedef enum logic {IDLE, WAIT} state_e;
endpackage

// File: rtl/cond_eval.sv
// cond_eval: evaluates an ARM condition code against NZCV flags.
module cond_eval
  import flag_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_true
);
  logic n, c, v, z, base;
  cond_e code;
  assign {n, c, v, z} = {flags[FLAG_N], flags[FLAG_C], flags[FLAG_V], flags[FLAG_Z]};
  assign code = cond_e'(cond);
  // odd codes invert their even partner, except NV which stays always-true like AL
  always_comb begin
    base = code[3:1] == EQ[3:1] ? z :
           code[3:1] == HS[3:1] ? c :
           code[3:1] == MI[3:1] ? n :
           code[3:1] == VS[3:1] ? v :
           code[3:1] == HI[3:1] ? c & ~z :
           code[3:1] == GE[3:1] ? n == v :
           code[3:1] == GT[3:1] ? ~z & (n == v) : 1'b1;
    cond_true = (code[0] && code != NV) ? ~base : base;
  end
endmodule

// File: rtl/flag_sched.sv
// flag_sched: stalls a B.cond sitting behind an in-flight flag setter and resolves it against NZCV.
module flag_sched
  import flag_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic             id_sets_flags,
  input  logic             id_is_bcond,
  input  logic [3:0]       id_cond,
  input  logic             stall_in,
  input  logic             flush,
  input  logic [3:0]       flags_q,
  output logic             flag_we,
  output logic             stall_out,
  output logic             br_taken,
  output logic [CNT_W-1:0] stall_cnt
);
  logic ex_valid_q, ex_sets_q, cond_ok;
  state_e state_q, state_d;
  cond_eval u_cond (.cond(id_cond), .flags(flags_q), .cond_true(cond_ok));
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_q <= 1'b0;
      ex_sets_q  <= 1'b0;
      stall_cnt  <= '0;
    end else begin
      ex_valid_q <= (flush | stall_in | stall_out) ? 1'b0 : id_valid;
      ex_sets_q  <= (flush | stall_in | stall_out) ? ex_sets_q : id_sets_flags;
      stall_cnt  <= (stall_out && !(&stall_cnt)) ? stall_cnt + 1'b1 : stall_cnt;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = (state_q == IDLE && stall_out) ? WAIT : IDLE;
  end
  // no EX flag forwarding: a B.cond behind a setter always waits for flags_q
  always_comb begin
    flag_we   = ex_valid_q & ex_sets_q;
    stall_out = (state_q == IDLE) & id_valid & id_is_bcond & ex_valid_q & ex_sets_q & ~flush;
    br_taken  = id_valid & id_is_bcond & ~stall_out & ~stall_in & ~flush & cond_ok;
  end
endmodule

// File: tb/tb_flag_sched.sv
// tb_flag_sched: directed scoreboard bench for flag_sched.
module tb_flag_sched;
  localparam int CNT_W = 4;
  typedef struct packed {
    logic       we;
    logic       st;
    logic       bt;
    logic [3:0] cnt;
  } exp_t;
  logic clk = 1'b0, reset;
  logic id_valid, id_sets_flags, id_is_bcond, stall_in, flush;
  logic [3:0] id_cond, flags_q;
  logic flag_we, stall_out, br_taken;
  logic [CNT_W-1:0] stall_cnt;
  exp_t q[$];
  int total = 0, bad = 0;
  flag_sched #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_sets_flags(id_sets_flags),
    .id_is_bcond(id_is_bcond), .id_cond(id_cond), .stall_in(stall_in), .flush(flush),
    .flags_q(flags_q), .flag_we(flag_we), .stall_out(stall_out), .br_taken(br_taken),
    .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("flag_we", int'(flag_we), int'(e.we));
      chk("stall_out", int'(stall_out), int'(e.st));
      chk("br_taken", int'(br_taken), int'(e.bt));
      chk("stall_cnt", int'(stall_cnt), int'(e.cnt));
    end
  end
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, cc, v, z;
    {n, cc, v, z} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cc;
      4'h3: return !cc;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cc && !z;
      4'h9: return !cc || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && n == v;
      4'hD: return z || n != v;
      default: return 1'b1;
    endcase
  endfunction
  task automatic step(input logic v, s, b, input logic [3:0] c, input logic si, fl,
                      input logic [3:0] fq, input logic ewe, est, ebt, input logic [3:0] ecnt);
    #1;
    reset = 1'b0;
    {id_valid, id_sets_flags, id_is_bcond, id_cond, stall_in, flush, flags_q} = {v, s, b, c, si, fl, fq};
    q.push_back('{we: ewe, st: est, bt: ebt, cnt: ecnt});
    @(posedge clk);
  endtask
  initial begin
    reset = 1'b1;
    {id_valid, id_sets_flags, id_is_bcond, id_cond, stall_in, flush, flags_q} = 13'($urandom);
    @(posedge clk);
    {id_valid, id_sets_flags, id_is_bcond, id_cond, stall_in, flush, flags_q} = 13'($urandom);
    @(posedge clk);
    step(0, 0, 0, 4'h0, 0, 0, 4'h0, 0, 0, 0, 4'd0);
    // ADDS then B.EQ: one stall, then resolve on the committed Z
    step(1, 1, 0, 4'h0, 0, 0, 4'h0, 0, 0, 0, 4'd0);
    step(1, 0, 1, 4'h0, 0, 0, 4'h0, 1, 1, 0, 4'd0);
    step(1, 0, 1, 4'h0, 0, 0, 4'h1, 0, 0, 1, 4'd1);
    step(0, 0, 0, 4'h0, 0, 0, 4'h1, 0, 0, 0, 4'd1);
    // SUBS, NOP, B.LT: no stall
    step(1, 1, 0, 4'h0, 0, 0, 4'h0, 0, 0, 0, 4'd1);
    step(1, 0, 0, 4'h0, 0, 0, 4'h0, 1, 0, 0, 4'd1);
    step(1, 0, 1, 4'hB, 0, 0, 4'h8, 0, 0, 1, 4'd1);
    step(0, 0, 0, 4'h0, 0, 0, 4'h0, 0, 0, 0, 4'd1);
    for (int c = 0; c < 16; c++)
      for (int f = 0; f < 16; f++)
        step(1, 0, 1, 4'(c), 0, 0, 4'(f), 0, 0, ref_cond(4'(c), 4'(f)), 4'd1);
    // flush beats a hazard and leaves no bubble-induced stall
    step(1, 1, 0, 4'h0, 0, 0, 4'h1, 0, 0, 0, 4'd1);
    step(1, 0, 1, 4'h0, 0, 1, 4'h1, 1, 0, 0, 4'd1);
    step(0, 0, 0, 4'h0, 0, 0, 4'h1, 0, 0, 0, 4'd1);
    // stall_in with a hazard still stalls and counts
    step(1, 1, 0, 4'h0, 0, 0, 4'h0, 0, 0, 0, 4'd1);
    step(1, 0, 1, 4'h1, 1, 0, 4'h0, 1, 1, 0, 4'd1);
    step(1, 0, 1, 4'h1, 0, 0, 4'h0, 0, 0, 1, 4'd2);
    step(0, 0, 0, 4'h0, 0, 0, 4'h0, 0, 0, 0, 4'd2);
    // 19 more stalls push the 4-bit counter past all-ones
    for (int i = 0; i < 19; i++) begin
      step(1, 1, 0, 4'h0, 0, 0, 4'h0, 0, 0, 0, 4'((2 + i) > 15 ? 15 : 2 + i));
      step(1, 0, 1, 4'h0, 0, 0, 4'h0, 1, 1, 0, 4'((2 + i) > 15 ? 15 : 2 + i));
      step(1, 0, 1, 4'h0, 0, 0, 4'h0, 0, 0, 0, 4'((3 + i) > 15 ? 15 : 3 + i));
    end
    step(0, 0, 0, 4'h0, 0, 0, 4'h0, 0, 0, 0, 4'hF);
    // back-to-back setters: consecutive flag_we, no stall
    step(1, 1, 0, 4'h0, 0, 0, 4'h0, 0, 0, 0, 4'hF);
    step(1, 1, 0, 4'h0, 0, 0, 4'h0, 1, 0, 0, 4'hF);
    step(0, 0, 0, 4'h0, 0, 0, 4'h0, 1, 0, 0, 4'hF);
    step(0, 0, 0, 4'h0, 0, 0, 4'h0, 0, 0, 0, 4'hF);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
